// File: rtl/agc_gain_apply.sv
// AGC gain stage: sign/magnitude split, serial shift-add multiply by an unsigned
// fixed-point gain, then round-half-away, symmetric saturation and sign restore.
`timescale 1ns / 1ps
module agc_gain_apply #(
  parameter int unsigned W_IN  = 26,
  parameter int unsigned W_G   = 16,
  parameter int unsigned FRAC  = 12,
  parameter int unsigned W_OUT = 26
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    In_valid,
  output logic                    In_ready,
  input  logic signed [W_IN-1:0]  Input_i,
  input  logic signed [W_IN-1:0]  Input_q,
  input  logic [W_G-1:0]          Gain,
  output logic                    Out_valid,
  input  logic                    Out_ready,
  output logic signed [W_OUT-1:0] Output_i,
  output logic signed [W_OUT-1:0] Output_q,
  output logic                    Sat_flag
);

  localparam int unsigned AW       = W_IN + W_G;
  localparam int unsigned CW       = (W_G > 1) ? $clog2(W_G) : 1;
  localparam logic [CW-1:0] CntLast = CW'(W_G - 1);
  localparam int unsigned RND_SH   = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [AW:0] Rnd      = (FRAC > 0) ? ((AW + 1)'(1) << RND_SH) : '0;
  localparam logic [AW:0] MaxMag   = ((AW + 1)'(1) << (W_OUT - 1)) - (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StMul, StScale, StHold} state_e;

  state_e                  state_q, state_d;
  logic [W_G-1:0]          gain_q, gain_d;
  logic                    sign_i_q, sign_i_d, sign_q_q, sign_q_d;
  logic [W_IN-1:0]         mag_i_q, mag_i_d, mag_q_q, mag_q_d;
  logic [AW-1:0]           acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [W_OUT-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic                    sat_q, sat_d;
  logic signed [W_OUT-1:0] scl_i, scl_q;
  logic                    sat_i, sat_qc;

  // Most negative input maps to 2^(W_IN-1), which still fits as unsigned.
  function automatic logic [W_IN-1:0] abs_mag(input logic signed [W_IN-1:0] x);
    return x[W_IN-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // Returns {sat, signed result}; rounding is applied to the magnitude.
  function automatic logic [W_OUT:0] round_sat(input logic [AW-1:0] acc, input logic neg);
    logic [AW:0]      r;
    logic [W_OUT-1:0] m;
    logic             sat;
    r   = ({1'b0, acc} + Rnd) >> FRAC;
    sat = (r > MaxMag);
    m   = sat ? MaxMag[W_OUT-1:0] : r[W_OUT-1:0];
    return {sat, (neg ? -m : m)};
  endfunction

  assign {sat_i, scl_i}  = round_sat(acc_i_q, sign_i_q);
  assign {sat_qc, scl_q} = round_sat(acc_q_q, sign_q_q);

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    sign_i_d = sign_i_q;
    sign_q_d = sign_q_q;
    mag_i_d  = mag_i_q;
    mag_q_d  = mag_q_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    cnt_d    = cnt_q;
    out_i_d  = out_i_q;
    out_q_d  = out_q_q;
    sat_d    = sat_q;
    In_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        In_ready = 1'b1;
        if (In_valid) begin
          gain_d   = Gain;
          sign_i_d = Input_i[W_IN-1];
          sign_q_d = Input_q[W_IN-1];
          mag_i_d  = abs_mag(Input_i);
          mag_q_d  = abs_mag(Input_q);
          acc_i_d  = '0;
          acc_q_d  = '0;
          cnt_d    = '0;
          state_d  = StMul;
        end
      end
      StMul: begin
        if (gain_q[cnt_q]) begin
          acc_i_d = acc_i_q + (AW'(mag_i_q) << cnt_q);
          acc_q_d = acc_q_q + (AW'(mag_q_q) << cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StScale;
      end
      StScale: begin
        out_i_d = scl_i;
        out_q_d = scl_q;
        sat_d   = sat_i | sat_qc;
        state_d = StHold;
      end
      StHold: begin
        if (Out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      gain_q   <= '0;
      sign_i_q <= 1'b0;
      sign_q_q <= 1'b0;
      mag_i_q  <= '0;
      mag_q_q  <= '0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      cnt_q    <= '0;
      out_i_q  <= '0;
      out_q_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      sign_i_q <= sign_i_d;
      sign_q_q <= sign_q_d;
      mag_i_q  <= mag_i_d;
      mag_q_q  <= mag_q_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      cnt_q    <= cnt_d;
      out_i_q  <= out_i_d;
      out_q_q  <= out_q_d;
      sat_q    <= sat_d;
    end
  end

  assign Out_valid = (state_q == StHold);
  assign Output_i  = out_i_q;
  assign Output_q  = out_q_q;
  assign Sat_flag  = sat_q;

endmodule

// File: tb/tb_agc_gain_apply.sv
// Bench for agc_gain_apply: directed cases plus randomized traffic checked
// against an arithmetic reference of round(|x|*G/2^FRAC), clip, sign.
`timescale 1ns / 1ps
module tb_agc_gain_apply;

  localparam int unsigned W_IN  = 26;
  localparam int unsigned W_G   = 16;
  localparam int unsigned FRAC  = 12;
  localparam int unsigned W_OUT = 26;

  logic                    Clk = 1'b0;
  logic                    Reset;
  logic                    In_valid;
  logic                    In_ready;
  logic signed [W_IN-1:0]  Input_i;
  logic signed [W_IN-1:0]  Input_q;
  logic [W_G-1:0]          Gain;
  logic                    Out_valid;
  logic                    Out_ready;
  logic signed [W_OUT-1:0] Output_i;
  logic signed [W_OUT-1:0] Output_q;
  logic                    Sat_flag;

  agc_gain_apply #(.W_IN(W_IN), .W_G(W_G), .FRAC(FRAC), .W_OUT(W_OUT)) dut (
    .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .In_ready(In_ready),
    .Input_i(Input_i), .Input_q(Input_q), .Gain(Gain), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Output_i(Output_i), .Output_q(Output_q), .Sat_flag(Sat_flag)
  );

  always #5 Clk = ~Clk;

  typedef struct {longint oi; longint oq; bit sat;} exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  bit   ov_prev = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   rdy_fix = 1'b1;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint ref_ch(input longint x, input longint g, output bit sat);
    longint m, r, lim;
    m = (x < 0) ? -x : x;
    r = m * g;
    if (FRAC > 0) r = r + (longint'(1) << (FRAC - 1));
    r   = r >> FRAC;
    lim = (longint'(1) << (W_OUT - 1)) - 1;
    sat = (r > lim);
    if (sat) r = lim;
    return (x < 0) ? -r : r;
  endfunction

  always @(posedge Clk) cyc++;

  initial begin
    forever begin
      @(posedge Clk);
      #1 Out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  // Per-cycle compare against the model queue; also checks handshake timing.
  always @(negedge Clk) begin
    if (Reset) begin
      exp_q.delete();
      ov_prev = 1'b0;
      chk(!Out_valid && Output_i == 0 && Output_q == 0 && !Sat_flag, "reset_outputs",
          longint'(Output_i), 0);
    end else begin
      chk(In_ready == (exp_q.size() == 0), "in_ready", longint'(In_ready),
          longint'(exp_q.size() == 0));
      if (Out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_out_valid", 1, 0);
        end else begin
          chk(longint'(Output_i) == exp_q[0].oi, "output_i", longint'(Output_i), exp_q[0].oi);
          chk(longint'(Output_q) == exp_q[0].oq, "output_q", longint'(Output_q), exp_q[0].oq);
          chk(Sat_flag == exp_q[0].sat, "sat_flag", longint'(Sat_flag), longint'(exp_q[0].sat));
          if (!ov_prev) chk(cyc - acc_edge == W_G + 1, "latency", cyc - acc_edge, W_G + 1);
          if (Out_ready) void'(exp_q.pop_front());
        end
      end
      ov_prev = Out_valid && !Out_ready;
      if (In_valid && In_ready) begin
        exp_t e;
        e.oi = ref_ch(longint'(Input_i), longint'(Gain), e.sat);
        begin
          bit sq;
          e.oq  = ref_ch(longint'(Input_q), longint'(Gain), sq);
          e.sat = e.sat | sq;
        end
        exp_q.push_back(e);
        acc_edge = cyc + 1;
      end
    end
  end

  task automatic send(input longint i, input longint q, input longint g);
    int n;
    @(posedge Clk);
    #1;
    In_valid = 1'b1;
    Input_i  = W_IN'(i);
    Input_q  = W_IN'(q);
    Gain     = W_G'(g);
    n = 0;
    @(negedge Clk);
    while (!In_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!In_ready) chk(1'b0, "accept_timeout", n, 200);
    @(posedge Clk);
    #1;
    In_valid = 1'b0;
    Input_i  = W_IN'($urandom);
    Input_q  = W_IN'($urandom);
    Gain     = W_G'($urandom);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge Clk);
    while (!Out_valid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!Out_valid) chk(1'b0, "out_valid_timeout", n, 100);
  endtask

  task automatic expect_lit(input string name, input longint ei, input longint eq,
                            input bit es);
    wait_out();
    chk(longint'(Output_i) == ei, {name, "_i"}, longint'(Output_i), ei);
    chk(longint'(Output_q) == eq, {name, "_q"}, longint'(Output_q), eq);
    chk(Sat_flag == es, {name, "_sat"}, longint'(Sat_flag), longint'(es));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint hold_i, hold_q, m;
    bit     s;
    int     lat, n;
    logic signed [W_IN-1:0] rx, ry;

    Reset = 1'b1; In_valid = 1'b0; Input_i = '0; Input_q = '0; Gain = '0; Out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk(In_ready == 1'b1, "reset_in_ready", longint'(In_ready), 1);
    chk(Out_valid == 1'b0, "reset_out_valid", longint'(Out_valid), 0);

    // Pin the model to hand-computed values.
    m = ref_ch(1000, 4096, s);
    chk(m == 1000 && !s, "model_unity", m, 1000);
    m = ref_ch(-3, 2048, s);
    chk(m == -2 && !s, "model_round", m, -2);
    m = ref_ch(longint'(1) << 24, 65535, s);
    chk(m == 33554431 && s, "model_sat", m, 33554431);

    // Unity gain plus explicit latency: Out_valid high in cycle W_G+2, accept cycle = 1.
    send(1000, -1000, 4096);
    lat = 0;
    @(negedge Clk);
    while (!Out_valid && lat < 100) begin
      lat++;
      @(negedge Clk);
    end
    chk(lat == W_G + 1, "t1_latency", lat, W_G + 1);
    chk(longint'(Output_i) == 1000 && longint'(Output_q) == -1000 && !Sat_flag, "t1_value",
        longint'(Output_i), 1000);

    send(3, -3, 2048);
    expect_lit("t2_three", 2, -2, 1'b0);
    send(1, -1, 2048);
    expect_lit("t2_one", 1, -1, 1'b0);
    send(0, 0, 2048);
    expect_lit("t2_zero", 0, 0, 1'b0);

    send(longint'(1) << 24, -(longint'(1) << 25), 65535);
    expect_lit("t3_sat", 33554431, -33554431, 1'b1);
    send(12345, -678, 0);
    expect_lit("gain_zero", 0, 0, 1'b0);

    // Backpressure: outputs hold and extra In_valid is ignored.
    rdy_fix = 1'b0;
    send(500, -700, 8192);
    expect_lit("t4_first", 1000, -1400, 1'b0);
    hold_i = longint'(Output_i);
    hold_q = longint'(Output_q);
    repeat (5) begin
      @(posedge Clk);
      #1;
      In_valid = 1'b1;
      Input_i  = W_IN'($urandom);
      Gain     = W_G'($urandom);
      @(negedge Clk);
      chk(Out_valid && longint'(Output_i) == hold_i && longint'(Output_q) == hold_q,
          "t4_hold", longint'(Output_i), hold_i);
      chk(!In_ready, "t4_in_ready", longint'(In_ready), 0);
    end
    @(posedge Clk);
    #1;
    In_valid = 1'b0;
    rdy_fix  = 1'b1;
    send(777, -333, 4096);
    expect_lit("t4_next", 777, -333, 1'b0);

    // Reset during MUL discards the sample at once.
    send(1000, -1000, 4096);
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    chk(!Out_valid && Output_i == 0 && Output_q == 0 && !Sat_flag, "t5_abort",
        longint'(Output_i), 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk(In_ready == 1'b1, "t5_in_ready", longint'(In_ready), 1);
    send(1000, -1000, 4096);
    expect_lit("t5_after", 1000, -1000, 1'b0);

    // Random traffic with random downstream stalls.
    rdy_rand = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      rx = W_IN'($urandom);
      ry = W_IN'($urandom);
      if ($urandom_range(0, 15) == 0) rx = {1'b1, {(W_IN - 1){1'b0}}};
      if ($urandom_range(0, 15) == 0) ry = {1'b1, {(W_IN - 1){1'b0}}};
      case ($urandom_range(0, 3))
        0: m = longint'($urandom_range(0, 65535));
        1: m = longint'($urandom_range(0, 8191));
        2: m = ($urandom_range(0, 1) != 0) ? 65535 : 0;
        default: m = longint'($urandom_range(0, 255));
      endcase
      send(longint'(rx), longint'(ry), m);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
